// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pipe_pkg
//  Purpose  : Shared definitions for the 5-stage MIPS pipeline hazard
//             controller. Contains the forward-select encodings, the
//             memory-handshake FSM state type and the register-match rule.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

  // ALU operand source select driven onto ForwardAE / ForwardBE
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Multi-cycle data memory handshake states
  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } mem_state_t;

  // A source register depends on a writer only when the writer really writes
  // and the register is not r0 (r0 is hard-wired to zero).
  function automatic logic reg_match(input logic [4:0] src,
                                     input logic [4:0] dst,
                                     input logic       we);
    return we && (src != 5'd0) && (src == dst);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Purpose  : Bundle of every datapath <-> hazard-controller signal.
//  Modports : master - datapath side (drives register ids, stage controls,
//                      mem_ready; receives stalls, flushes, forwards)
//             slave  - hazard controller side (the reverse)
//  Params   : PERF_W - width of the stall_cycles performance counter
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  // Register ids per stage
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  // Stage controls
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM, MemWriteM;
  logic       BranchD, PCSrcD, JumpD;
  // Data memory handshake
  logic       mem_ready;
  logic       mem_req;
  // Pipeline register control
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM,
    output BranchD, PCSrcD, JumpD, mem_ready,
    input  mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, stall_cycles
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM,
    input  BranchD, PCSrcD, JumpD, mem_ready,
    output mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_cmp
//  Purpose  : Purely combinational register-match logic. Produces the
//             forward selects and the data-hazard stall request (hz).
//  Macro    : FORWARD_EN - when defined, forwarding paths are used and only
//             load-use / branch dependencies stall. When undefined, all
//             forwards are tied to the register file and any in-flight
//             writer of a decode source stalls until it has written back.
//  Ports    : in  RsD,RtD,RsE,RtE          source register ids
//             in  WriteRegE/M/W, RegWriteE/M/W  destination + write enable
//             in  MemtoRegE, MemtoRegM, BranchD
//             out ForwardAE/BE (2b), ForwardAD/BD (1b), hz
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_cmp
  import mips_pipe_pkg::*;
(
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       hz
);

  logic lw_stall;
  logic br_stall;
  logic dep_e, dep_m, dep_w;

  // Decode sources against each downstream writer
  assign dep_e = reg_match(RsD, WriteRegE, RegWriteE) | reg_match(RtD, WriteRegE, RegWriteE);
  assign dep_m = reg_match(RsD, WriteRegM, RegWriteM) | reg_match(RtD, WriteRegM, RegWriteM);
  assign dep_w = reg_match(RsD, WriteRegW, RegWriteW) | reg_match(RtD, WriteRegW, RegWriteW);

  // A load in E writes RtE; its data is not available for one more cycle.
  assign lw_stall = MemtoRegE & (reg_match(RsD, RtE, RegWriteE) | reg_match(RtD, RtE, RegWriteE));

  // Branches resolve in D: an ALU result still in E, or a load still in M,
  // cannot reach the comparator in time.
  assign br_stall = BranchD & (dep_e | (MemtoRegM & dep_m));

`ifdef FORWARD_EN
  always_comb begin
    ForwardAE = FWD_RF;
    if (reg_match(RsE, WriteRegM, RegWriteM))      ForwardAE = FWD_MEM;
    else if (reg_match(RsE, WriteRegW, RegWriteW)) ForwardAE = FWD_WB;

    ForwardBE = FWD_RF;
    if (reg_match(RtE, WriteRegM, RegWriteM))      ForwardBE = FWD_MEM;
    else if (reg_match(RtE, WriteRegW, RegWriteW)) ForwardBE = FWD_WB;
  end

  assign ForwardAD = reg_match(RsD, WriteRegM, RegWriteM);
  assign ForwardBD = reg_match(RtD, WriteRegM, RegWriteM);
  assign hz        = lw_stall | br_stall;
`else
  assign ForwardAE = FWD_RF;
  assign ForwardBE = FWD_RF;
  assign ForwardAD = 1'b0;
  assign ForwardBD = 1'b0;
  // Without forwarding, hold decode until no stage still owes a write.
  assign hz        = lw_stall | br_stall | dep_e | dep_m | dep_w;
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB
//             pipeline registers. Combines data/branch hazards with a
//             request/ready handshake for a multi-cycle data memory and
//             counts stalled fetch cycles.
//  Macro    : FORWARD_EN - enables the forwarding network (see
//             hazard_fwd_cmp); undefined gives stall-until-writeback.
//  Params   : PERF_W - width of the saturating stall-cycle counter
//  Ports    : clk   in  rising-edge clock
//             rst_n in  synchronous active-low reset
//             bus   slave modport of pipe_hazard_ctrl_if
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_hazard_ctrl_if.slave     bus
);

  mem_state_t        state, state_next;
  logic              mem_req_m;
  logic              req_raw;
  logic              mem_stall;
  logic              hz;
  logic              redirect;
  logic [1:0]        fwd_ae, fwd_be;
  logic              fwd_ad, fwd_bd;
  logic              stall_f, stall_d, stall_e, stall_m;
  logic              flush_d, flush_e, flush_w;
  logic [PERF_W-1:0] stall_cnt;

  hazard_fwd_cmp u_cmp (
    .RsD       (bus.RsD),
    .RtD       (bus.RtD),
    .RsE       (bus.RsE),
    .RtE       (bus.RtE),
    .WriteRegE (bus.WriteRegE),
    .WriteRegM (bus.WriteRegM),
    .WriteRegW (bus.WriteRegW),
    .RegWriteE (bus.RegWriteE),
    .RegWriteM (bus.RegWriteM),
    .RegWriteW (bus.RegWriteW),
    .MemtoRegE (bus.MemtoRegE),
    .MemtoRegM (bus.MemtoRegM),
    .BranchD   (bus.BranchD),
    .ForwardAE (fwd_ae),
    .ForwardBE (fwd_be),
    .ForwardAD (fwd_ad),
    .ForwardBD (fwd_bd),
    .hz        (hz)
  );

  // ---------------------------------------------------------------- memory FSM
  assign mem_req_m = bus.MemtoRegM | bus.MemWriteM;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= MS_IDLE;
    else        state <= state_next;
  end

  // DONE is a one-cycle release: the access in M moves on while the FSM
  // refuses to look at MemReqM, so the same access is never issued twice.
  always_comb begin
    state_next = state;
    req_raw    = 1'b0;
    mem_stall  = 1'b0;
    unique case (state)
      MS_IDLE: begin
        if (mem_req_m) begin
          req_raw    = 1'b1;
          mem_stall  = 1'b1;
          state_next = MS_BUSY;
        end
      end
      MS_BUSY: begin
        req_raw   = 1'b1;
        mem_stall = 1'b1;
        if (bus.mem_ready) state_next = MS_DONE;
      end
      MS_DONE: state_next = MS_IDLE;
      default: state_next = MS_IDLE;
    endcase
  end

  // --------------------------------------------------------- stall / flush mux
  assign redirect = (bus.PCSrcD & bus.BranchD) | bus.JumpD;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst_n) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything upstream of WB; WB gets a bubble so the stalled
      // instruction in M does not retire repeatedly.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = hz;
      stall_d = hz;
      flush_e = hz;
      // A stalled branch re-evaluates next cycle, so do not redirect yet.
      flush_d = redirect & ~hz;
    end
  end

  // ------------------------------------------------------------------ counter
  always_ff @(posedge clk) begin
    if (!rst_n)                         stall_cnt <= '0;
    else if (stall_f && !(&stall_cnt))  stall_cnt <= stall_cnt + 1'b1;
  end

  // ------------------------------------------------------------------ outputs
  assign bus.mem_req      = rst_n & req_raw;
  assign bus.StallF       = stall_f;
  assign bus.StallD       = stall_d;
  assign bus.StallE       = stall_e;
  assign bus.StallM       = stall_m;
  assign bus.FlushD       = flush_d;
  assign bus.FlushE       = flush_e;
  assign bus.FlushW       = flush_w;
  assign bus.ForwardAE    = rst_n ? fwd_ae : FWD_RF;
  assign bus.ForwardBE    = rst_n ? fwd_be : FWD_RF;
  assign bus.ForwardAD    = rst_n & fwd_ad;
  assign bus.ForwardBD    = rst_n & fwd_bd;
  assign bus.stall_cycles = stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl. A second instance
//             with a 4-bit counter shares the stimulus for saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

`ifdef FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.PERF_W(32)) i0 ();
  pipe_hazard_ctrl_if #(.PERF_W(4))  i1 ();

  pipe_hazard_ctrl #(.PERF_W(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(i0));
  pipe_hazard_ctrl #(.PERF_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(i1));

  assign i1.RsD = i0.RsD;             assign i1.RtD = i0.RtD;
  assign i1.RsE = i0.RsE;             assign i1.RtE = i0.RtE;
  assign i1.WriteRegE = i0.WriteRegE; assign i1.WriteRegM = i0.WriteRegM;
  assign i1.WriteRegW = i0.WriteRegW; assign i1.RegWriteE = i0.RegWriteE;
  assign i1.RegWriteM = i0.RegWriteM; assign i1.RegWriteW = i0.RegWriteW;
  assign i1.MemtoRegE = i0.MemtoRegE; assign i1.MemtoRegM = i0.MemtoRegM;
  assign i1.MemWriteM = i0.MemWriteM; assign i1.BranchD = i0.BranchD;
  assign i1.PCSrcD = i0.PCSrcD;       assign i1.JumpD = i0.JumpD;
  assign i1.mem_ready = i0.mem_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state: an access is outstanding, or it just completed
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int unsigned exp_cnt = 0;

  function automatic bit writes(input logic [4:0] src, input logic [4:0] dst, input logic we);
    return (we === 1'b1) && (src != 5'd0) && (src == dst);
  endfunction

  // Returns {mem_req, StallF,D,E,M, FlushD,E,W, ForwardAE, ForwardBE, ForwardAD, ForwardBD}
  function automatic logic [13:0] model_out();
    logic [4:0] dst [3];
    logic       we  [3];
    logic [1:0] fae, fbe;
    logic       fad, fbd, lw, br, dep, hz, req, sf, sd, se, sm, fd, fe, fw;
    dst[0] = i0.WriteRegE; we[0] = i0.RegWriteE;
    dst[1] = i0.WriteRegM; we[1] = i0.RegWriteM;
    dst[2] = i0.WriteRegW; we[2] = i0.RegWriteW;
    fae = 2'b00; fbe = 2'b00; fad = 1'b0; fbd = 1'b0; dep = 1'b0;
    if (writes(i0.RsE, dst[1], we[1]))      fae = 2'b10;
    else if (writes(i0.RsE, dst[2], we[2])) fae = 2'b01;
    if (writes(i0.RtE, dst[1], we[1]))      fbe = 2'b10;
    else if (writes(i0.RtE, dst[2], we[2])) fbe = 2'b01;
    fad = writes(i0.RsD, dst[1], we[1]);
    fbd = writes(i0.RtD, dst[1], we[1]);
    lw  = i0.MemtoRegE && (writes(i0.RsD, i0.RtE, i0.RegWriteE) || writes(i0.RtD, i0.RtE, i0.RegWriteE));
    br  = i0.BranchD && (writes(i0.RsD, dst[0], we[0]) || writes(i0.RtD, dst[0], we[0]) ||
          (i0.MemtoRegM && (writes(i0.RsD, dst[1], we[1]) || writes(i0.RtD, dst[1], we[1]))));
    for (int k = 0; k < 3; k++)
      if (writes(i0.RsD, dst[k], we[k]) || writes(i0.RtD, dst[k], we[k])) dep = 1'b1;
    if (!FWD_ON) begin
      fae = 2'b00; fbe = 2'b00; fad = 1'b0; fbd = 1'b0;
    end
    hz  = lw || br || (!FWD_ON && dep);
    req = m_busy || (!m_done && (i0.MemtoRegM || i0.MemWriteM));
    {sf, sd, se, sm, fd, fe, fw} = 7'b0;
    if (!rst_n) begin
      req = 1'b0; fd = 1'b1; fe = 1'b1; fw = 1'b1;
      fae = 2'b00; fbe = 2'b00; fad = 1'b0; fbd = 1'b0;
    end else if (req) begin
      {sf, sd, se, sm, fw} = 5'b11111;
    end else begin
      sf = hz; sd = hz; fe = hz;
      fd = ((i0.PCSrcD && i0.BranchD) || i0.JumpD) && !hz;
    end
    return {req, sf, sd, se, sm, fd, fe, fw, fae, fbe, fad, fbd};
  endfunction

  // Called between negedge and posedge: moves the model across the next edge.
  task automatic advance();
    logic [13:0] e;
    e = model_out();
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; exp_cnt = 0;
    end else begin
      if (e[12]) exp_cnt++;
      if (m_done)      m_done = 1'b0;
      else if (m_busy) begin
        if (i0.mem_ready) begin m_busy = 1'b0; m_done = 1'b1; end
      end
      else if (i0.MemtoRegM || i0.MemWriteM) m_busy = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i0.RsD = 5'd0; i0.RtD = 5'd0; i0.RsE = 5'd0; i0.RtE = 5'd0;
    i0.WriteRegE = 5'd0; i0.WriteRegM = 5'd0; i0.WriteRegW = 5'd0;
    i0.RegWriteE = 1'b0; i0.RegWriteM = 1'b0; i0.RegWriteW = 1'b0;
    i0.MemtoRegE = 1'b0; i0.MemtoRegM = 1'b0; i0.MemWriteM = 1'b0;
    i0.BranchD = 1'b0; i0.PCSrcD = 1'b0; i0.JumpD = 1'b0; i0.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    i0.RsE = 5'd3; i0.WriteRegM = 5'd3; i0.RegWriteM = 1'b1; i0.MemtoRegM = 1'b1;
    @(negedge clk);
    checks++;
    if ({i0.FlushD, i0.FlushE, i0.FlushW} !== 3'b111) begin
      errors++; $display("FAIL reset_flush: got %b need 111", {i0.FlushD, i0.FlushE, i0.FlushW});
    end
    checks++;
    if ({i0.mem_req, i0.StallF, i0.StallD, i0.StallE, i0.StallM, i0.ForwardAE} !== 7'b0) begin
      errors++; $display("FAIL reset_quiet: got %b need 0", {i0.mem_req, i0.StallF, i0.StallD, i0.StallE, i0.StallM, i0.ForwardAE});
    end
    advance();
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (i0.stall_cycles !== 32'd0 || i0.mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_state: cnt %0d mem_req %b need 0 0", i0.stall_cycles, i0.mem_req);
    end
    advance();
  endtask

  task automatic test_raw();
    clear_inputs();
    i0.RsE = 5'd3; i0.WriteRegM = 5'd3; i0.RegWriteM = 1'b1;
    @(negedge clk);
    checks++;
    if (i0.ForwardAE !== (FWD_ON ? 2'b10 : 2'b00)) begin
      errors++; $display("FAIL raw_mem: ForwardAE %b need %b", i0.ForwardAE, FWD_ON ? 2'b10 : 2'b00);
    end
    advance();
    i0.WriteRegM = 5'd0; i0.WriteRegW = 5'd3; i0.RegWriteW = 1'b1;
    @(negedge clk);
    checks++;
    if (i0.ForwardAE !== (FWD_ON ? 2'b01 : 2'b00)) begin
      errors++; $display("FAIL raw_wb: ForwardAE %b need %b", i0.ForwardAE, FWD_ON ? 2'b01 : 2'b00);
    end
    advance();
    i0.RegWriteW = 1'b0; i0.WriteRegW = 5'd0; i0.RsE = 5'd0;
    @(negedge clk);
    checks++;
    if (i0.ForwardAE !== 2'b00) begin
      errors++; $display("FAIL raw_r0: ForwardAE %b need 00", i0.ForwardAE);
    end
    advance();
    // M and W both write r6: MEM wins
    i0.RtE = 5'd6; i0.WriteRegM = 5'd6; i0.WriteRegW = 5'd6; i0.RegWriteW = 1'b1;
    @(negedge clk);
    checks++;
    if (i0.ForwardBE !== (FWD_ON ? 2'b10 : 2'b00)) begin
      errors++; $display("FAIL raw_prio: ForwardBE %b need %b", i0.ForwardBE, FWD_ON ? 2'b10 : 2'b00);
    end
    advance();
    clear_inputs();
    i0.RsD = 5'd4; i0.WriteRegM = 5'd4; i0.RegWriteM = 1'b1;
    @(negedge clk);
    checks++;
    if ({i0.ForwardAD, i0.StallF} !== (FWD_ON ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL raw_dec: ForwardAD,StallF %b need %b", {i0.ForwardAD, i0.StallF}, FWD_ON ? 2'b10 : 2'b01);
    end
    advance();
  endtask

  task automatic test_load_use();
    clear_inputs();
    i0.MemtoRegE = 1'b1; i0.RegWriteE = 1'b1; i0.RtE = 5'd5; i0.WriteRegE = 5'd5; i0.RsD = 5'd5;
    @(negedge clk);
    checks++;
    if ({i0.StallF, i0.StallD, i0.FlushE, i0.FlushD} !== 4'b1110) begin
      errors++; $display("FAIL load_use: got %b need 1110", {i0.StallF, i0.StallD, i0.FlushE, i0.FlushD});
    end
    advance();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (i0.stall_cycles !== exp_cnt || i0.StallF !== 1'b0) begin
      errors++; $display("FAIL load_use_cnt: cnt %0d StallF %b need %0d 0", i0.stall_cycles, i0.StallF, exp_cnt);
    end
    advance();
  endtask

  task automatic test_branch();
    clear_inputs();
    i0.BranchD = 1'b1; i0.PCSrcD = 1'b1; i0.RsD = 5'd8; i0.RtD = 5'd9;
    @(negedge clk);
    checks++;
    if ({i0.FlushD, i0.StallF} !== 2'b10) begin
      errors++; $display("FAIL branch_taken: FlushD,StallF %b need 10", {i0.FlushD, i0.StallF});
    end
    advance();
    i0.RegWriteE = 1'b1; i0.WriteRegE = 5'd8;
    @(negedge clk);
    checks++;
    if ({i0.FlushD, i0.StallF} !== 2'b01) begin
      errors++; $display("FAIL branch_stall: FlushD,StallF %b need 01", {i0.FlushD, i0.StallF});
    end
    advance();
    clear_inputs();
    i0.JumpD = 1'b1;
    @(negedge clk);
    checks++;
    if ({i0.FlushD, i0.FlushE} !== 2'b10) begin
      errors++; $display("FAIL jump: FlushD,FlushE %b need 10", {i0.FlushD, i0.FlushE});
    end
    advance();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    i0.MemtoRegM = 1'b1; i0.RegWriteM = 1'b1; i0.WriteRegM = 5'd10;
    for (int c = 0; c < 4; c++) begin
      i0.mem_ready = (c == 3);
      @(negedge clk);
      checks++;
      if ({i0.mem_req, i0.StallF, i0.StallD, i0.StallE, i0.StallM, i0.FlushW, i0.FlushD, i0.FlushE} !== 8'b11111100) begin
        errors++; $display("FAIL mem_wait c%0d: got %b need 11111100", c,
          {i0.mem_req, i0.StallF, i0.StallD, i0.StallE, i0.StallM, i0.FlushW, i0.FlushD, i0.FlushE});
      end
      advance();
    end
    // DONE: pipe advances once; a stray mem_ready here is ignored
    @(negedge clk);
    checks++;
    if ({i0.mem_req, i0.StallF, i0.StallM, i0.FlushW} !== 4'b0000) begin
      errors++; $display("FAIL mem_done: got %b need 0000", {i0.mem_req, i0.StallF, i0.StallM, i0.FlushW});
    end
    advance();
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({i0.mem_req, i0.StallF} !== 2'b00) begin
      errors++; $display("FAIL mem_idle: got %b need 00", {i0.mem_req, i0.StallF});
    end
    advance();
  endtask

  task automatic test_reset_busy();
    clear_inputs();
    i0.MemWriteM = 1'b1;
    advance();
    advance();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({i0.mem_req, i0.StallF, i0.FlushD, i0.FlushE, i0.FlushW} !== 5'b00111) begin
      errors++; $display("FAIL reset_busy: got %b need 00111", {i0.mem_req, i0.StallF, i0.FlushD, i0.FlushE, i0.FlushW});
    end
    advance();
    rst_n = 1'b1;
    i0.MemWriteM = 1'b0;
    @(negedge clk);
    checks++;
    if (i0.mem_req !== 1'b0 || i0.stall_cycles !== 32'd0 || i0.StallF !== 1'b0) begin
      errors++; $display("FAIL reset_busy_after: mem_req %b cnt %0d StallF %b need 0 0 0", i0.mem_req, i0.stall_cycles, i0.StallF);
    end
    advance();
  endtask

  task automatic test_no_forward();
    clear_inputs();
    i0.RsE = 5'd7; i0.RsD = 5'd7; i0.WriteRegM = 5'd7; i0.RegWriteM = 1'b1;
    @(negedge clk);
    checks++;
    if ({i0.ForwardAE, i0.ForwardAD, i0.StallF} !== (FWD_ON ? 4'b1010 : 4'b0001)) begin
      errors++; $display("FAIL nofwd_m: got %b need %b", {i0.ForwardAE, i0.ForwardAD, i0.StallF}, FWD_ON ? 4'b1010 : 4'b0001);
    end
    advance();
    i0.WriteRegM = 5'd0; i0.RegWriteM = 1'b0; i0.WriteRegW = 5'd7; i0.RegWriteW = 1'b1;
    @(negedge clk);
    checks++;
    if ({i0.ForwardAE, i0.StallF} !== (FWD_ON ? 3'b010 : 3'b001)) begin
      errors++; $display("FAIL nofwd_w: got %b need %b", {i0.ForwardAE, i0.StallF}, FWD_ON ? 3'b010 : 3'b001);
    end
    advance();
    i0.WriteRegW = 5'd0; i0.RegWriteW = 1'b0;
    @(negedge clk);
    checks++;
    if ({i0.ForwardAE, i0.StallF} !== 3'b000) begin
      errors++; $display("FAIL nofwd_gone: got %b need 000", {i0.ForwardAE, i0.StallF});
    end
    advance();
  endtask

  task automatic test_saturation();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    advance();
    rst_n = 1'b1;
    i0.MemtoRegE = 1'b1; i0.RegWriteE = 1'b1; i0.RtE = 5'd5; i0.WriteRegE = 5'd5; i0.RtD = 5'd5;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 10) begin
        checks++;
        if (i1.stall_cycles !== 4'd10) begin
          errors++; $display("FAIL sat_mid: cnt %0d need 10", i1.stall_cycles);
        end
      end
      advance();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (i1.stall_cycles !== 4'd15) begin
      errors++; $display("FAIL sat_top: cnt %0d need 15", i1.stall_cycles);
    end
    checks++;
    if (i0.stall_cycles !== exp_cnt) begin
      errors++; $display("FAIL sat_wide: cnt %0d need %0d", i0.stall_cycles, exp_cnt);
    end
    advance();
  endtask

  task automatic test_random();
    logic [13:0] e, got;
    for (int n = 0; n < 400; n++) begin
      rst_n        = ($urandom_range(0, 59) != 0);
      i0.RsD       = 5'($urandom_range(0, 3));
      i0.RtD       = 5'($urandom_range(0, 3));
      i0.RsE       = 5'($urandom_range(0, 3));
      i0.RtE       = 5'($urandom_range(0, 3));
      i0.WriteRegE = 5'($urandom_range(0, 3));
      i0.WriteRegM = 5'($urandom_range(0, 3));
      i0.WriteRegW = 5'($urandom_range(0, 3));
      i0.RegWriteE = 1'($urandom_range(0, 1));
      i0.RegWriteM = 1'($urandom_range(0, 1));
      i0.RegWriteW = 1'($urandom_range(0, 1));
      i0.MemtoRegE = ($urandom_range(0, 3) == 0);
      i0.MemtoRegM = ($urandom_range(0, 4) == 0);
      i0.MemWriteM = ($urandom_range(0, 6) == 0);
      i0.BranchD   = 1'($urandom_range(0, 1));
      i0.PCSrcD    = 1'($urandom_range(0, 1));
      i0.JumpD     = ($urandom_range(0, 4) == 0);
      i0.mem_ready = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      e   = model_out();
      got = {i0.mem_req, i0.StallF, i0.StallD, i0.StallE, i0.StallM, i0.FlushD, i0.FlushE, i0.FlushW,
             i0.ForwardAE, i0.ForwardBE, i0.ForwardAD, i0.ForwardBD};
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL random_outputs cycle %0d: got %b need %b", n, got, e);
      end
      checks++;
      if (i0.stall_cycles !== exp_cnt) begin
        errors++; $display("FAIL random_count cycle %0d: got %0d need %0d", n, i0.stall_cycles, exp_cnt);
      end
      advance();
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    advance();
    test_reset();
    test_raw();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_reset_busy();
    test_no_forward();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
